sha3_theta_pipe: RTL and testbench

- Parametrised, flow-controlled Keccak theta step for any lane width of Keccak-f[25*LANE_W] (LANE_W = 1..64).
- Sits between the round-input mux and rho/pi. Replaces the fixed-64-bit, free-running theta with a valid/ready pipeline that supports backpressure, reset and an optional input capture stage.

---
 rtl/sha3_theta_pipe.sv | 127 ++++++++++++
 tb/tb_sha3_theta_pipe.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_theta_pipe.sv
// Keccak theta step as a flow-controlled pipeline for any lane width.
// Optional input capture stage, then column-parity stage, then output stage.
module sha3_theta_pipe #(
  parameter int LANE_W    = 64,
  parameter bit INPUT_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*LANE_W-1:0]   isa,
  input  logic [5*LANE_W-1:0]   isb,
  input  logic [5*LANE_W-1:0]   isc,
  input  logic [5*LANE_W-1:0]   isd,
  input  logic [5*LANE_W-1:0]   ise,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5*LANE_W-1:0]   osa,
  output logic [5*LANE_W-1:0]   osb,
  output logic [5*LANE_W-1:0]   osc,
  output logic [5*LANE_W-1:0]   osd,
  output logic [5*LANE_W-1:0]   ose,
  output logic [1:0]            inflight
);

  localparam int RW = 5 * LANE_W;
  localparam int SW = 25 * LANE_W;

  logic          advance;
  logic [SW-1:0] in_st;
  logic          s0_v;
  logic [SW-1:0] s0_st;
  logic          s0_cnt;
  logic          s1_v;
  logic [SW-1:0] s1_st;
  logic [RW-1:0] s1_c;
  logic          s2_v;
  logic [SW-1:0] s2_st;
  logic [RW-1:0] c_nxt;
  logic [RW-1:0] d;
  logic [SW-1:0] a_nxt;

  // Lane (x,y) lives at bit offset (5*y+x)*LANE_W; row y=0 is lowest.
  assign in_st    = {ise, isd, isc, isb, isa};
  assign advance  = !s2_v || out_ready;
  assign in_ready = advance;

  function automatic logic [LANE_W-1:0] rotl1(
    input logic [LANE_W-1:0] v
  );
    return (v << 1) | (v >> (LANE_W - 1));
  endfunction

  generate
    if (INPUT_REG) begin : g_s0
      always_ff @(posedge clk) begin
        if (!rstn) begin
          s0_v  <= 1'b0;
          s0_st <= '0;
        end else if (advance) begin
          s0_v  <= in_valid;
          s0_st <= in_st;
        end
      end
      assign s0_cnt = s0_v;
    end else begin : g_bypass
      assign s0_v   = in_valid;
      assign s0_st  = in_st;
      assign s0_cnt = 1'b0;
    end
  endgenerate

  always_comb begin
    c_nxt = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        c_nxt[x*LANE_W +: LANE_W] ^=
          s0_st[(5*y+x)*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    d = '0;
    for (int x = 0; x < 5; x++) begin
      d[x*LANE_W +: LANE_W] =
        s1_c[((x+4)%5)*LANE_W +: LANE_W] ^
        rotl1(s1_c[((x+1)%5)*LANE_W +: LANE_W]);
    end
  end

  always_comb begin
    a_nxt = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        a_nxt[(5*y+x)*LANE_W +: LANE_W] =
          s1_st[(5*y+x)*LANE_W +: LANE_W] ^
          d[x*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v  <= 1'b0;
      s1_st <= '0;
      s1_c  <= '0;
      s2_v  <= 1'b0;
      s2_st <= '0;
    end else if (advance) begin
      s1_v  <= s0_v;
      s1_st <= s0_st;
      s1_c  <= c_nxt;
      s2_v  <= s1_v;
      s2_st <= a_nxt;
    end
  end

  assign out_valid = s2_v;
  assign osa       = s2_st[0*RW +: RW];
  assign osb       = s2_st[1*RW +: RW];
  assign osc       = s2_st[2*RW +: RW];
  assign osd       = s2_st[3*RW +: RW];
  assign ose       = s2_st[4*RW +: RW];
  assign inflight  = {1'b0, s0_cnt} + {1'b0, s1_v} + {1'b0, s2_v};

endmodule

// File: tb/tb_sha3_theta_pipe.sv
// Bench for sha3_theta_pipe: several width/capture configurations,
// directed vectors plus a queue scoreboard over random streams.
module tb_sha3_theta_pipe;

  localparam int NCFG = 8;

  typedef logic [1599:0] st_t;

  function automatic int lw_of(input int k);
    case (k)
      0: return 64;
      1: return 8;
      2: return 1;
      3: return 1;
      4: return 16;
      5: return 16;
      6: return 32;
      default: return 32;
    endcase
  endfunction

  function automatic int ir_of(input int k);
    case (k)
      0, 1, 3, 5, 7: return 1;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic st_t set_lane(input st_t v, input int x,
                                   input int y, input int w,
                                   input logic [63:0] val);
    st_t r;
    r = v;
    for (int i = 0; i < w; i++) r[(5*y+x)*w+i] = val[i];
    return r;
  endfunction

  // Single nonzero lane A[0][0]=vid: D[1]=vid, D[4]=vrot, D[0]=0.
  function automatic st_t exp_bit(input int w, input logic [63:0] vid,
                                  input logic [63:0] vrot);
    st_t r;
    r = '0;
    r = set_lane(r, 0, 0, w, vid);
    for (int y = 0; y < 5; y++) begin
      r = set_lane(r, 1, y, w, vid);
      r = set_lane(r, 4, y, w, vrot);
    end
    return r;
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int K  = k;
    localparam int W  = lw_of(k);
    localparam int IR = ir_of(k);
    localparam int RW = 5 * W;
    localparam int SW = 25 * W;

    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] st_in = '0;
    wire           in_ready;
    wire           out_valid;
    wire  [1:0]    inflight;
    wire  [SW-1:0] st_out;
    logic [SW-1:0] sb[$];

    sha3_theta_pipe #(
      .LANE_W   (W),
      .INPUT_REG(IR != 0)
    ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .isa      (st_in[0*RW +: RW]),
      .isb      (st_in[1*RW +: RW]),
      .isc      (st_in[2*RW +: RW]),
      .isd      (st_in[3*RW +: RW]),
      .ise      (st_in[4*RW +: RW]),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .osa      (st_out[0*RW +: RW]),
      .osb      (st_out[1*RW +: RW]),
      .osc      (st_out[2*RW +: RW]),
      .osd      (st_out[3*RW +: RW]),
      .ose      (st_out[4*RW +: RW]),
      .inflight (inflight)
    );

    function automatic logic [SW-1:0] model(input logic [SW-1:0] a);
      logic [W-1:0]  c [5];
      logic [W-1:0]  dd [5];
      logic [W-1:0]  t;
      logic [SW-1:0] r;
      for (int x = 0; x < 5; x++) begin
        c[x] = '0;
        for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[(5*y+x)*W +: W];
      end
      for (int x = 0; x < 5; x++) begin
        for (int i = 0; i < W; i++) t[i] = c[(x+1)%5][(i+W-1)%W];
        dd[x] = c[(x+4)%5] ^ t;
      end
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          r[(5*y+x)*W +: W] = a[(5*y+x)*W +: W] ^ dd[x];
      return r;
    endfunction

    function automatic int bad_lane(input logic [SW-1:0] a,
                                    input logic [SW-1:0] b);
      for (int l = 0; l < 25; l++)
        if (a[l*W +: W] !== b[l*W +: W]) return l;
      return 0;
    endfunction

    function automatic logic [SW-1:0] rand_st();
      st_t tmp;
      for (int i = 0; i < 50; i++) tmp[i*32 +: 32] = $urandom;
      return tmp[SW-1:0];
    endfunction

    task automatic chk_idle(input string nm);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_valid cfg%0d got %b want 0", nm, K, out_valid);
      end
      checks++;
      if (inflight !== 2'd0) begin
        failures++;
        $display("FAIL %s_inflight cfg%0d got %0d want 0",
                 nm, K, inflight);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_ready cfg%0d got %b want 1", nm, K, in_ready);
      end
      checks++;
      if (st_out !== '0) begin
        failures++;
        $display("FAIL %s_data cfg%0d lane%0d got %h want 0", nm, K,
                 bad_lane(st_out, '0),
                 st_out[bad_lane(st_out, '0)*W +: W]);
      end
    endtask

    task automatic send_check(input st_t a, input st_t ex,
                              input string nm);
      logic [SW-1:0] e;
      int lat;
      e = ex[SW-1:0];
      in_valid  = 1'b1;
      st_in     = a[SW-1:0];
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_accept cfg%0d got %b want 1", nm, K, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != IR + 2) begin
        failures++;
        $display("FAIL %s_latency cfg%0d got %0d want %0d",
                 nm, K, lat, IR + 2);
      end
      checks++;
      if (st_out !== e) begin
        failures++;
        $display("FAIL %s_data cfg%0d lane%0d got %h want %h", nm, K,
                 bad_lane(st_out, e), st_out[bad_lane(st_out, e)*W +: W],
                 e[bad_lane(st_out, e)*W +: W]);
      end
      checks++;
      if (st_out !== model(a[SW-1:0])) begin
        failures++;
        $display("FAIL %s_model cfg%0d lane%0d differs", nm, K,
                 bad_lane(st_out, model(a[SW-1:0])));
      end
      @(posedge clk);
      #1;
    endtask

    task automatic run(input int n, input int pv, input int pr,
                       input int stall_len, input string nm);
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int stall_left = 0;
      int max_if = 0;
      int budget;
      bit stall_done = 1'b0;
      bit acc = 1'b0;
      logic [SW-1:0] held;
      logic [SW-1:0] e;
      budget = 40 * n + 200;
      held = '0;
      sb.delete();
      in_valid = 1'b0;
      while (got < n && cyc < budget) begin
        if (stall_len > 0 && !stall_done && out_valid) begin
          stall_left = stall_len;
          held       = st_out;
          stall_done = 1'b1;
        end
        if (!in_valid || acc) begin
          if (sent < n && $urandom_range(99) < pv) begin
            in_valid = 1'b1;
            st_in    = rand_st();
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < pr);
        #1;
        checks++;
        if (int'(inflight) != sb.size()) begin
          failures++;
          $display("FAIL %s_inflight cfg%0d got %0d want %0d",
                   nm, K, inflight, sb.size());
        end
        if (int'(inflight) > max_if) max_if = int'(inflight);
        if (stall_left > 0) begin
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_stall_ready cfg%0d got %b want 0",
                     nm, K, in_ready);
          end
          checks++;
          if (out_valid !== 1'b1 || st_out !== held) begin
            failures++;
            $display("FAIL %s_hold cfg%0d lane%0d got %h want %h", nm, K,
                     bad_lane(st_out, held),
                     st_out[bad_lane(st_out, held)*W +: W],
                     held[bad_lane(st_out, held)*W +: W]);
          end
          stall_left--;
        end
        acc = in_valid && in_ready;
        if (acc) begin
          sb.push_back(model(st_in));
          sent++;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_extra cfg%0d got output want none", nm, K);
          end else begin
            e = sb.pop_front();
            if (st_out !== e) begin
              failures++;
              $display("FAIL %s_out cfg%0d lane%0d got %h want %h", nm, K,
                       bad_lane(st_out, e),
                       st_out[bad_lane(st_out, e)*W +: W],
                       e[bad_lane(st_out, e)*W +: W]);
            end
          end
          got++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != n) begin
        failures++;
        $display("FAIL %s_count cfg%0d got %0d want %0d", nm, K, got, n);
      end
      if (stall_len > 0) begin
        checks++;
        if (max_if != IR + 2 || !stall_done) begin
          failures++;
          $display("FAIL %s_saturate cfg%0d got %0d want %0d",
                   nm, K, max_if, IR + 2);
        end
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
        failures++;
        $display("FAIL %s_drain cfg%0d got valid=%b q=%0d want 0/0",
                 nm, K, out_valid, sb.size());
      end
    endtask

    task automatic reset_mid(input string nm);
      sb.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        st_in = rand_st();
        @(posedge clk);
        #1;
      end
      checks++;
      if (inflight !== 2'(IR + 2)) begin
        failures++;
        $display("FAIL %s_fill cfg%0d got %0d want %0d",
                 nm, K, inflight, IR + 2);
      end
      rstn  = 1'b0;
      st_in = rand_st();
      @(posedge clk);
      #1;
      rstn      = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk_idle(nm);
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s_stale cfg%0d cycle%0d got 1 want 0",
                   nm, K, i);
        end
      end
    endtask
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    g_cfg[0].chk_idle("reset");
    g_cfg[2].chk_idle("reset");
  endtask

  task automatic test_zero();
    g_cfg[0].send_check('0, '0, "zero");
    g_cfg[2].send_check('0, '0, "zero");
  endtask

  task automatic test_single_bit();
    g_cfg[0].send_check(set_lane('0, 0, 0, 64, 64'h1),
                        exp_bit(64, 64'h1, 64'h2), "bit");
    g_cfg[6].send_check(set_lane('0, 0, 0, 32, 64'h1),
                        exp_bit(32, 64'h1, 64'h2), "bit");
  endtask

  task automatic test_wrap();
    g_cfg[1].send_check(set_lane('0, 0, 0, 8, 64'h80),
                        exp_bit(8, 64'h80, 64'h01), "wrap");
  endtask

  task automatic test_backpressure();
    g_cfg[0].run(5, 100, 100, 4, "bp");
    g_cfg[4].run(5, 100, 100, 4, "bp");
  endtask

  task automatic test_back_to_back();
    g_cfg[0].run(20, 100, 100, 0, "b2b");
  endtask

  task automatic test_reset_mid();
    g_cfg[0].reset_mid("rstmid");
  endtask

  task automatic test_sweep();
    g_cfg[2].run(1000, 70, 70, 0, "sweep");
    g_cfg[3].run(1000, 70, 70, 0, "sweep");
    g_cfg[4].run(1000, 70, 70, 0, "sweep");
    g_cfg[5].run(1000, 70, 70, 0, "sweep");
    g_cfg[6].run(1000, 70, 70, 0, "sweep");
    g_cfg[7].run(1000, 70, 70, 0, "sweep");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero();
    test_single_bit();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
